// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte sources,
// with locked multi-byte bursts and a start-to-busy timeout flag.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err,
    input  logic                       err_clr
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d, gid_q, gid_d, win;
    logic                found, lock_q, lock_d, start_q, start_d, gv_q, gv_d, err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   data_q, data_d;

    // first requester at or after ptr+1, wrapping
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        start_d = 1'b0;
        data_d  = data_q;
        gv_d    = gv_q;
        err_d   = err_q & ~err_clr;
        case (state_q)
            IDLE: begin
                gv_d = !tx_busy && !lock_q && found;
                if (gv_d) begin
                    gid_d   = win;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (req[gid_q]) begin
                    start_d      = 1'b1;
                    data_d       = req_data[int'(gid_q)*DATA_W +: DATA_W];
                    ack_d[gid_q] = 1'b1;
                    lock_d       = ~req_last[gid_q];
                    ptr_d        = gid_q;
                    cnt_d        = '0;
                    state_d      = WAIT_BUSY;
                end else begin
                    lock_d  = 1'b0;
                    gv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    gv_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (lock_q && req[gid_q]) begin
                        state_d = LOAD;
                    end else begin
                        lock_d  = 1'b0;
                        gv_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            gid_q   <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            gv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            data_q  <= data_d;
            gv_q    <= gv_d;
            err_q   <= err_d;
        end
    end

    assign req_ack     = ack_q;
    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign grant_valid = gv_q;
    assign grant_id    = gid_q;
    assign timeout_err = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; requester queues and a transmitter model drive the DUT,
// a monitor checks every tx_start against the expected (owner, byte) sequence.
module tb_uart_tx_arbiter;
    localparam int N = 4, W = 8, TO = 16;

    logic           clk = 1'b0, rst = 1'b1, tx_busy = 1'b0, err_clr = 1'b0;
    logic [N-1:0]   req = '0, req_last = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ack;
    logic           tx_start, grant_valid, timeout_err;
    logic [W-1:0]   tx_data;
    logic [1:0]     grant_id;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .START_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_valid(grant_valid), .grant_id(grant_id), .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [1:0] id; logic [7:0] data;} exp_t;

    int         cyc = 0, total = 0, bad = 0, busy_len = 30, start_cyc = 0;
    int         rise_cyc [N];
    bit         tx_en = 1'b1, chk_lat = 1'b0;
    exp_t       sb_q [$];
    logic [8:0] src_q [N][$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic last, input bit expect_it);
        src_q[id].push_back({last, d});
        if (expect_it) sb_q.push_back({2'(id), d});
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        while (n < budget && !(sb_q.size() == 0 && !tx_busy && !grant_valid && src_empty())) begin
            tick();
            n++;
        end
        chk("drain", 32'(n < budget), 1);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb_q.delete();
        tick();
        rst = 1'b0;
    endtask

    // requesters: hold the head byte until acked, then present the next one
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            logic was;
            was = req[i];
            if (req_ack[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            req[i] = src_q[i].size() != 0;
            if (req[i]) {req_last[i], req_data[i*W +: W]} = src_q[i][0];
            if (req[i] && !was) rise_cyc[i] = cyc;
        end
    end

    // transmitter: busy rises two cycles after start and lasts busy_len cycles
    initial forever begin
        @(negedge clk);
        if (tx_start && tx_en) begin
            repeat (2) @(posedge clk);
            #2 tx_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #2 tx_busy = 1'b0;
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && (tx_start || req_ack != '0))
            chk("ack_onehot", 32'(req_ack), tx_start ? 32'(1 << grant_id) : 32'd0);
        if (!rst && tx_start) begin
            start_cyc = cyc;
            chk("start_while_busy", 32'(tx_busy), 0);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_start: got id=%0d data=%0h expected none", grant_id, tx_data);
            end else begin
                e = sb_q.pop_front();
                chk("grant_id", 32'(grant_id), 32'(e.id));
                chk("tx_data", 32'(tx_data), 32'(e.data));
            end
            if (chk_lat) chk("latency", 32'(cyc - rise_cyc[grant_id]), 2);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) send(i, 8'(8'hA0 + i), 1'b1, 1'b1);
        tick();
        tick();
        chk("reset_out", {req_ack, tx_start, tx_data, grant_valid, grant_id, timeout_err}, 0);
        rst = 1'b0;
        wait_idle(1000);

        do_reset();
        busy_len = 4340;
        chk_lat  = 1'b1;
        send(2, 8'h41, 1'b1, 1'b1);
        n = 0;
        do begin tick(); n++; end while (!tx_busy && n < 20);
        chk("busy_rise", 32'(tx_busy), 1);
        chk("gv_during_busy", 32'(grant_valid), 1);
        chk("gid_during_busy", 32'(grant_id), 2);
        n = 0;
        do begin tick(); n++; end while (tx_busy && n < 5000);
        chk("busy_fall", 32'(tx_busy), 0);
        tick();
        chk("gv_after_busy", 32'(grant_valid), 0);
        chk_lat  = 1'b0;
        busy_len = 30;

        do_reset();
        send(0, 8'h10, 1'b1, 1'b1);
        send(1, 8'h11, 1'b1, 1'b1);
        send(2, 8'h12, 1'b1, 1'b1);
        send(3, 8'h13, 1'b1, 1'b1);
        send(0, 8'h14, 1'b1, 1'b1);
        send(1, 8'h15, 1'b1, 1'b1);
        wait_idle(2000);

        do_reset();
        send(0, 8'h4E, 1'b0, 1'b1);
        send(0, 8'h2D, 1'b0, 1'b1);
        send(0, 8'h49, 1'b1, 1'b1);
        send(1, 8'h21, 1'b1, 1'b1);
        wait_idle(2000);

        do_reset();
        tx_en = 1'b0;
        send(1, 8'h55, 1'b1, 1'b1);
        n = 0;
        do begin tick(); n++; end while (!timeout_err && n < 100);
        chk("timeout_set", 32'(timeout_err), 1);
        chk("timeout_latency", 32'(cyc - start_cyc), TO);
        chk("gv_after_timeout", 32'(grant_valid), 0);
        tx_en = 1'b1;
        send(1, 8'h66, 1'b1, 1'b1);
        wait_idle(500);
        chk("timeout_sticky", 32'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("timeout_cleared", 32'(timeout_err), 0);

        do_reset();
        send(3, 8'h31, 1'b0, 1'b1);
        send(3, 8'h32, 1'b0, 1'b1);
        send(3, 8'h33, 1'b1, 1'b0);
        n = 0;
        do begin tick(); n++; end while (!(sb_q.size() == 0 && tx_busy) && n < 500);
        chk("burst_byte2_busy", 32'(tx_busy), 1);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        tick();
        chk("midburst_reset_out", {req_ack, tx_start, grant_valid, grant_id}, 0);
        rst = 1'b0;
        send(0, 8'h01, 1'b1, 1'b1);
        send(3, 8'h03, 1'b1, 1'b1);
        wait_idle(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
